inst_rom_loader: RTL

//  Responder end of the core's instruction-fetch interface. The core presents ce/addr and this block returns the instruction word the same cycle.

---
 rtl/inst_rom_loader_pkg.sv | 26 ++
 rtl/inst_rom_loader_if.sv | 25 ++
 rtl/inst_rom_loader_ld_word_pack.sv | 54 +++++
 rtl/inst_rom_loader.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/inst_rom_loader_pkg.sv
// ---------------------------------------------------------------------------
// inst_rom_loader_pkg
//   Shared constants and types for the instruction ROM / program loader.
//   Contents:
//     CHIP_ENABLE        active level of the core's fetch chip enable
//     INST_BUS_W         instruction word width
//     INST_ADDR_W        fetch address width
//     INST_MEM_NUM_LOG2  default log2 of memory depth in words
//     ZERO_WORD_DEFAULT  default idle value of the fetch data bus
//     ld_state_t         loader FSM states (RUN / LOAD / DRAIN)
// ---------------------------------------------------------------------------
package inst_rom_loader_pkg;

    localparam logic        CHIP_ENABLE       = 1'b1;
    localparam int          INST_BUS_W        = 32;
    localparam int          INST_ADDR_W       = 32;
    localparam int          INST_MEM_NUM_LOG2 = 17;
    localparam logic [31:0] ZERO_WORD_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        LD_RUN   = 2'd0,
        LD_LOAD  = 2'd1,
        LD_DRAIN = 2'd2
    } ld_state_t;

endpackage

// File: rtl/inst_rom_loader_if.sv
// ---------------------------------------------------------------------------
// inst_rom_loader_if
//   Byte-serial loader stream with valid/ready handshake.
//     ld_data_i   loader byte          (master -> slave)
//     ld_valid_i  loader byte valid    (master -> slave)
//     ld_ready_o  slave accepts byte   (slave  -> master)
//   A byte transfers on a rising clock edge where valid and ready are both 1.
// ---------------------------------------------------------------------------
interface inst_rom_loader_if;
    logic [7:0] ld_data_i;
    logic       ld_valid_i;
    logic       ld_ready_o;

    modport master (
        output ld_data_i,
        output ld_valid_i,
        input  ld_ready_o
    );

    modport slave (
        input  ld_data_i,
        input  ld_valid_i,
        output ld_ready_o
    );
endinterface

// File: rtl/inst_rom_loader_ld_word_pack.sv
// ---------------------------------------------------------------------------
// ld_word_pack
//   Packs accepted bytes big-endian into 32-bit words.
//   Ports:
//     clk         clock
//     srst        synchronous active-high reset (clears counter and pack reg)
//     clear       synchronous clear at the start of a new load
//     byte_valid  a byte is accepted this cycle
//     byte_data   accepted byte
//     word_valid  pulse (combinational) on the 4th accepted byte of a word
//     word        packed word, valid while word_valid is high
// ---------------------------------------------------------------------------
module ld_word_pack (
    input  logic        clk,
    input  logic        srst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  bcnt_reg, bcnt_next;
    // Holds the first three bytes of the word; the first byte ends up on top.
    logic [23:0] pack_reg, pack_next;

    always_comb begin
        bcnt_next  = bcnt_reg;
        pack_next  = pack_reg;
        word_valid = 1'b0;
        // The 4th byte bypasses the register so the word is ready on the
        // same edge that accepts it.
        word       = {pack_reg, byte_data};
        if (clear) begin
            bcnt_next = 2'd0;
            pack_next = 24'd0;
        end else if (byte_valid) begin
            pack_next  = {pack_reg[15:0], byte_data};
            bcnt_next  = bcnt_reg + 2'd1;
            word_valid = (bcnt_reg == 2'd3);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            bcnt_reg <= 2'd0;
            pack_reg <= 24'd0;
        end else begin
            bcnt_reg <= bcnt_next;
            pack_reg <= pack_next;
        end
    end

endmodule

// File: rtl/inst_rom_loader.sv
// ---------------------------------------------------------------------------
// inst_rom_loader
//   Instruction memory for the core with a byte-serial program loader.
//   The core fetches combinationally; a load writes words from index 0 up
//   while holding the core in reset.
//   Ports:
//     clk           clock
//     rst           synchronous active-high reset
//     ce_i          fetch chip enable from core
//     addr_i        fetch byte address (word index = addr_i[DEPTH_LOG2+1:2])
//     inst_o        fetched instruction (combinational)
//     load_start_i  one-cycle load request
//     load_len_i    number of words to load, sampled with load_start_i
//     ld            loader byte stream (slave side)
//     cpu_rst_o     reset to the core, active-high
//     load_done_o   one-cycle pulse: load completed
//     load_err_o    one-cycle pulse: load request rejected (too long)
// ---------------------------------------------------------------------------
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int          DEPTH_LOG2 = INST_MEM_NUM_LOG2,
    parameter logic [31:0] ZERO_WORD  = ZERO_WORD_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce_i,
    input  logic [31:0]           addr_i,
    output logic [31:0]           inst_o,
    input  logic                  load_start_i,
    input  logic [DEPTH_LOG2:0]   load_len_i,
    inst_rom_loader_if.slave      ld,
    output logic                  cpu_rst_o,
    output logic                  load_done_o,
    output logic                  load_err_o
);

    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] MAX_LEN  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] LEN_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] WCNT_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    ld_state_t             state_reg, state_next;
    logic [DEPTH_LOG2:0]   len_reg, len_next;
    logic [DEPTH_LOG2-1:0] wcnt_reg, wcnt_next;
    logic                  done_reg, done_next;
    logic                  err_reg, err_next;
    // Keeps the core in reset for the first cycle after rst is released.
    logic                  hold_reg;

    logic                  pack_clear;
    logic                  byte_fire;
    logic                  word_valid;
    logic [31:0]           word;
    logic                  mem_we;
    logic                  last_word;

    logic [31:0]           mem [DEPTH];

    assign ld.ld_ready_o = (state_reg == LD_LOAD);
    assign byte_fire     = ld.ld_valid_i && ld.ld_ready_o;
    assign last_word     = ({1'b0, wcnt_reg} == (len_reg - LEN_ONE));

    ld_word_pack u_pack (
        .clk        (clk),
        .srst       (rst),
        .clear      (pack_clear),
        .byte_valid (byte_fire),
        .byte_data  (ld.ld_data_i),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        wcnt_next  = wcnt_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        pack_clear = 1'b0;
        mem_we     = 1'b0;
        case (state_reg)
            LD_RUN: begin
                if (load_start_i) begin
                    if (load_len_i > MAX_LEN) begin
                        err_next = 1'b1;
                    end else if (load_len_i == '0) begin
                        done_next = 1'b1;
                    end else begin
                        len_next   = load_len_i;
                        wcnt_next  = '0;
                        pack_clear = 1'b1;
                        state_next = LD_LOAD;
                    end
                end
            end
            LD_LOAD: begin
                if (word_valid) begin
                    mem_we    = !rst;
                    wcnt_next = wcnt_reg + WCNT_ONE;
                    if (last_word) begin
                        state_next = LD_DRAIN;
                    end
                end
            end
            LD_DRAIN: begin
                // One guard cycle after the last write before the core runs.
                state_next = LD_RUN;
                done_next  = 1'b1;
            end
            default: begin
                state_next = LD_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= LD_RUN;
            len_reg   <= '0;
            wcnt_reg  <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            hold_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            wcnt_reg  <= wcnt_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            hold_reg  <= 1'b0;
        end
    end

    // Memory contents survive reset, so the write port has no reset branch.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wcnt_reg] <= word;
        end
    end

    assign inst_o = ((ce_i == CHIP_ENABLE) && (state_reg == LD_RUN))
                    ? mem[addr_i[DEPTH_LOG2+1:2]] : ZERO_WORD;

    // Byte offset and bits above the memory range are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:DEPTH_LOG2+2], addr_i[1:0]};

    assign cpu_rst_o   = hold_reg || (state_reg != LD_RUN);
    assign load_done_o = done_reg;
    assign load_err_o  = err_reg;

endmodule
